// File: rtl/mem_in_fetch.sv
// rtl/mem_in_fetch.sv - frame fetcher from SRAM into a small output FIFO (optional macro MEM_IN_FETCH_STALL_CNT_EN adds stall_cnt)
module mem_in_fetch #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 64,
  parameter int NUM_WORDS  = 32768,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              sram_cen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_row,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef MEM_IN_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              iss_last;
  logic              wr_pend;
  logic [2:0]        wr_row;
  logic              wr_last;
  logic              push, pop;
  logic [CNT_W:0]    committed;
  logic              credit_ok;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [2:0]        fifo_row  [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  // sram_cen low means a read is on the bus now; wr_pend means its data is on sram_q now.
  // Both count against FIFO space so returning data always has a slot.
  assign committed = {1'b0, count} + (CNT_W+1)'(wr_pend) + (CNT_W+1)'(!sram_cen);
  assign credit_ok = committed < (CNT_W+1)'(FIFO_DEPTH);

  assign push      = wr_pend;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign busy      = (state != IDLE);

  // Head outputs read zero while the FIFO is empty so reset values hold without clearing storage
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_row   = out_valid ? fifo_row[rd_ptr]  : 3'd0;
  assign out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and read-issue decision; a start launches address 0 on the accepting edge
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = rd_addr;
    case (state)
      IDLE: begin
        issue_addr = '0;
        if (start) begin
          issue     = 1'b1;
          state_nxt = (LAST_ADDR == '0) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM read pipeline, FIFO pointers/occupancy and the done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_cen  <= 1'b1;
      sram_addr <= '0;
      rd_addr   <= '0;
      iss_last  <= 1'b0;
      wr_pend   <= 1'b0;
      wr_row    <= 3'd0;
      wr_last   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done      <= 1'b0;
    end else begin
      sram_cen <= !issue;
      if (issue) begin
        sram_addr <= issue_addr;
        rd_addr   <= issue_addr + ADDR_W'(1);
        iss_last  <= (issue_addr == LAST_ADDR);
      end
      wr_pend <= !sram_cen;
      if (!sram_cen) begin
        wr_row  <= sram_addr[2:0];
        wr_last <= iss_last;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      done  <= (state == DRAIN) && pop && out_last;
    end
  end

  // FIFO storage; no reset needed because the head is masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= sram_q;
      fifo_row[wr_ptr]  <= wr_row;
      fifo_last[wr_ptr] <= wr_last;
    end
  end

`ifdef MEM_IN_FETCH_STALL_CNT_EN
  // Backpressure counter: cycles the head waited on downstream during a frame, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (busy && out_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_in_fetch.sv
// tb/tb_mem_in_fetch.sv - directed bench for mem_in_fetch on three frame sizes (32768, 16, 64 words)
module tb_mem_in_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic        start [3];
  logic        ready [3];
  logic        cen   [3];
  logic [14:0] addr  [3];
  logic        valid [3];
  logic [63:0] data  [3];
  logic [2:0]  row   [3];
  logic        last  [3];
  logic        busy  [3];
  logic        done  [3];
`ifdef MEM_IN_FETCH_STALL_CNT_EN
  logic [31:0] stall [3];
`endif

  localparam logic [86:0] RST_VEC = {1'b1, 86'd0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NW = (g == 0) ? 32768 : ((g == 1) ? 16 : 64);
    logic [63:0] sram_q;

    always @(posedge clk) begin
      if (!cen[g]) sram_q <= {4{16'(addr[g])}};
    end

    mem_in_fetch #(.ADDR_W(15), .DATA_W(64), .NUM_WORDS(NW), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .reset(rst_n), .start(start[g]),
      .sram_cen(cen[g]), .sram_addr(addr[g]), .sram_q(sram_q),
      .out_valid(valid[g]), .out_ready(ready[g]), .out_data(data[g]),
      .out_row(row[g]), .out_last(last[g]), .busy(busy[g]), .done(done[g])
`ifdef MEM_IN_FETCH_STALL_CNT_EN
      , .stall_cnt(stall[g])
`endif
    );
  end

  function automatic logic [63:0] word(input int i);
    logic [15:0] w;
    w = i[15:0];
    return {4{w}};
  endfunction

  function automatic logic [86:0] outs(input int k);
    return {cen[k], addr[k], valid[k], data[k], row[k], last[k], busy[k], done[k]};
  endfunction

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      ready[k] = 1'b0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (outs(k) !== RST_VEC) begin
        bad++;
        $display("FAIL reset_outputs[%0d] got=%h want=%h", k, outs(k), RST_VEC);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame;
    int exp_i, gaps, errs, cyc, dones;
    ready[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b1 || valid[0] !== 1'b0) begin
      bad++; $display("FAIL full_accept busy=%b valid=%b want busy=1 valid=0", busy[0], valid[0]);
    end
    @(negedge clk);
    total++;
    if (valid[0] !== 1'b0) begin
      bad++; $display("FAIL full_early_valid got=%b want=0", valid[0]);
    end
    @(negedge clk);
    total++;
    if (valid[0] !== 1'b1 || data[0] !== word(0)) begin
      bad++; $display("FAIL full_first_latency valid=%b data=%h want 1/%h", valid[0], data[0], word(0));
    end
    exp_i = 0; gaps = 0; errs = 0; cyc = 0; dones = 0;
    while (exp_i < 32768 && cyc < 40000) begin
      if (done[0]) dones++;
      if (valid[0]) begin
        if (data[0] !== word(exp_i) || row[0] !== 3'(exp_i % 8) || last[0] !== (exp_i == 32767)) errs++;
        exp_i++;
      end else gaps++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (exp_i != 32768) begin
      bad++; $display("FAIL full_count got=%0d want=32768", exp_i);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL full_order errors=%0d want=0", errs);
    end
    total++;
    if (gaps != 0) begin
      bad++; $display("FAIL full_throughput gaps=%0d want=0", gaps);
    end
    total++;
    if (dones != 0 || done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL full_done early=%0d done=%b busy=%b want 0/1/0", dones, done[0], busy[0]);
    end
    @(negedge clk);
    total++;
    if (done[0] !== 1'b0) begin
      bad++; $display("FAIL full_done_pulse got=%b want=0", done[0]);
    end
  endtask

  task automatic test_stall_hold;
    int lows, head_errs, exp_i, errs, dones, cyc;
    ready[1] = 1'b0;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    lows = 0; head_errs = 0;
    for (int c = 0; c < 20; c++) begin
      if (!cen[1]) lows++;
      if (valid[1] && (data[1] !== word(0) || row[1] !== 3'd0 || last[1] !== 1'b0)) head_errs++;
      @(negedge clk);
    end
    total++;
    if (lows != 4) begin
      bad++; $display("FAIL stall_reads got=%0d want=4", lows);
    end
    total++;
    if (head_errs != 0 || valid[1] !== 1'b1 || data[1] !== word(0)) begin
      bad++; $display("FAIL stall_head errors=%0d valid=%b data=%h want 0/1/%h", head_errs, valid[1], data[1], word(0));
    end
    ready[1] = 1'b1;
    exp_i = 0; errs = 0; dones = 0; cyc = 0;
    while (dones == 0 && cyc < 200) begin
      if (done[1]) dones++;
      else if (valid[1]) begin
        if (data[1] !== word(exp_i) || last[1] !== (exp_i == 15)) errs++;
        exp_i++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (exp_i != 16 || errs != 0 || dones != 1) begin
      bad++; $display("FAIL stall_drain words=%0d errors=%0d dones=%0d want 16/0/1", exp_i, errs, dones);
    end
  endtask

  task automatic test_random_ready;
    int exp_i, errs, stab, dones, cyc;
    logic hold;
    logic [63:0] prev;
    hold = 1'b0; prev = '0;
    ready[2] = 1'b0;
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    exp_i = 0; errs = 0; stab = 0; dones = 0; cyc = 0;
    while (dones == 0 && cyc < 2000) begin
      if (done[2]) dones++;
      if (hold && (valid[2] !== 1'b1 || data[2] !== prev)) stab++;
      ready[2] = ($urandom_range(0, 1) == 1);
      if (valid[2]) begin
        if (ready[2]) begin
          if (data[2] !== word(exp_i) || row[2] !== 3'(exp_i % 8)) errs++;
          exp_i++;
        end
        hold = !ready[2];
        prev = data[2];
      end else hold = 1'b0;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (exp_i != 64 || errs != 0) begin
      bad++; $display("FAIL random_order words=%0d errors=%0d want 64/0", exp_i, errs);
    end
    total++;
    if (stab != 0) begin
      bad++; $display("FAIL random_hold_stable errors=%0d want=0", stab);
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL random_done got=%0d want=1", dones);
    end
  endtask

  task automatic test_start_ignored;
    int exp_i, errs, dones;
    ready[2] = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    exp_i = 0; errs = 0; dones = 0;
    for (int c = 0; c < 300; c++) begin
      if (done[2]) dones++;
      start[2] = valid[2] && (exp_i == 10);
      if (valid[2]) begin
        if (data[2] !== word(exp_i)) errs++;
        exp_i++;
      end
      @(negedge clk);
    end
    start[2] = 1'b0;
    total++;
    if (exp_i != 64 || errs != 0 || dones != 1 || busy[2] !== 1'b0) begin
      bad++; $display("FAIL restart_ignored words=%0d errors=%0d dones=%0d busy=%b want 64/0/1/0", exp_i, errs, dones, busy[2]);
    end
  endtask

  task automatic test_reset_mid;
    int exp_i, cyc, dones, errs;
    ready[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    exp_i = 0; cyc = 0;
    while (!(valid[0] && exp_i == 100) && cyc < 400) begin
      if (valid[0]) exp_i++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (exp_i != 100 || data[0] !== word(100)) begin
      bad++; $display("FAIL midreset_reach words=%0d data=%h want 100/%h", exp_i, data[0], word(100));
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs(0) !== RST_VEC) begin
      bad++; $display("FAIL midreset_async got=%h want=%h", outs(0), RST_VEC);
    end
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done[0]) dones++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done[0]) dones++;
    end
    total++;
    if (dones != 0 || outs(0) !== RST_VEC) begin
      bad++; $display("FAIL midreset_no_done dones=%0d outs=%h want 0/%h", dones, outs(0), RST_VEC);
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    total++;
    if (cen[0] !== 1'b0 || addr[0] !== 15'd0) begin
      bad++; $display("FAIL midreset_refetch cen=%b addr=%0d want 0/0", cen[0], addr[0]);
    end
    repeat (2) @(negedge clk);
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid[0] !== 1'b1 || data[0] !== word(k) || row[0] !== 3'(k)) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL midreset_restart_words errors=%0d want=0", errs);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef MEM_IN_FETCH_STALL_CNT_EN
  task automatic test_stall_cnt;
    int xfers, stalled, dones, cyc;
    logic [31:0] at_done;
    ready[2] = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    xfers = 0; stalled = 0; dones = 0; cyc = 0; at_done = '0;
    while (dones == 0 && cyc < 400) begin
      if (done[2]) begin
        dones++;
        at_done = stall[2];
      end
      if (valid[2] && xfers == 5 && stalled < 7) begin
        ready[2] = 1'b0;
        stalled++;
      end else ready[2] = 1'b1;
      if (valid[2] && ready[2]) xfers++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (dones != 1 || at_done !== 32'd7) begin
      bad++; $display("FAIL stall_cnt dones=%0d cnt=%0d want 1/7", dones, at_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_stall_hold();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
`ifdef MEM_IN_FETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
